uart_cmd_decoder: RTL and testbench

//  Packet decoder between uart_rx and mode_mux. Parses the UART byte stream into VRAM writes
//  (user_addr/user_data_in/user_we) and display-mode selection. Replaces the raw byte-append

---
 rtl/gpu_cmd_pkg.sv | 31 +++
 rtl/byte_timeout.sv | 27 ++
 rtl/uart_cmd_decoder.sv | 148 ++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/gpu_cmd_pkg.sv
// rtl/gpu_cmd_pkg.sv - opcodes, FSM states and display-mode encodings for the UART command decoder
package gpu_cmd_pkg;

   localparam logic [7:0] OP_SET_ADDR = 8'hA0;
   localparam logic [7:0] OP_WRITE    = 8'hA1;
   localparam logic [7:0] OP_SET_MODE = 8'hA2;
   localparam logic [7:0] OP_FILL     = 8'hA3;

   localparam int VRAM_LAST_DEFAULT = 22499;

   localparam logic [2:0] MODE_OFF   = 3'd0;
   localparam logic [2:0] MODE_TEXT  = 3'd1;
   localparam logic [2:0] MODE_GFX6  = 3'd2;
   localparam logic [2:0] MODE_GFX4  = 3'd3;
   localparam logic [2:0] MODE_GFX2  = 3'd4;
   localparam logic [2:0] MODE_TILED = 3'd5;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR_HI,
      ST_ADDR_LO,
      ST_LEN,
      ST_DATA,
      ST_MODE_ARG,
      ST_FILL_CH,
      ST_FILL_CL,
      ST_FILL_VAL,
      ST_FILL_RUN
   } state_t;

endpackage

// File: rtl/byte_timeout.sv
// rtl/byte_timeout.sv - inter-byte idle counter; tc pulses on the LIMIT-th enabled cycle since clear
module byte_timeout #(
   parameter int LIMIT = 100000
) (
   input  logic clk10m,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CW = $clog2(LIMIT + 1);
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

   logic [CW-1:0] cnt;

   assign tc = en && (cnt == LAST);

   always_ff @(posedge clk10m) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tc ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - UART byte-stream packet decoder to VRAM writes and display mode
// Optional FILL command (0xA3) built only when CMD_FILL_EN is defined.
module uart_cmd_decoder
   import gpu_cmd_pkg::*;
#(
   parameter int          ADDR_W         = 15,
   parameter int          VRAM_LAST      = VRAM_LAST_DEFAULT,
   parameter int          TIMEOUT_CYCLES = 100000,
   parameter logic [2:0]  RESET_MODE     = MODE_TEXT
) (
   input  logic              clk10m,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ack,
   output logic [ADDR_W-1:0] vram_addr,
   output logic [7:0]        vram_data,
   output logic              vram_we,
   output logic [2:0]        mode_out,
   output logic              busy,
   output logic              err
);

   localparam logic [ADDR_W-1:0] LAST_A = VRAM_LAST[ADDR_W-1:0];

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-9:0] addr_hi;
   logic [8:0]        remaining;
   logic              can_take;
   logic              tmo;
   logic              accept;
   logic [ADDR_W-1:0] ptr_next;
   logic [ADDR_W-1:0] new_addr;

`ifdef CMD_FILL_EN
   logic [15:0] fill_cnt;
   logic [7:0]  fill_val;
   assign can_take = (state != ST_FILL_RUN);
`else
   assign can_take = 1'b1;
`endif

   // Timer is frozen (not cleared) while a fill burst owns the write port.
   byte_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
      .clk10m (clk10m),
      .rst    (rst),
      .clr    (accept || (state == ST_IDLE)),
      .en     ((state != ST_IDLE) && can_take),
      .tc     (tmo)
   );

   assign accept   = in_valid && !in_ack && can_take && !tmo;
   assign ptr_next = (ptr == LAST_A) ? '0 : ptr + 1'b1;
   assign new_addr = {addr_hi, in_data};
   assign busy     = (state != ST_IDLE);

   always_ff @(posedge clk10m) begin
      if (rst) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         addr_hi   <= '0;
         remaining <= '0;
         in_ack    <= 1'b0;
         vram_we   <= 1'b0;
         vram_addr <= '0;
         vram_data <= '0;
         mode_out  <= RESET_MODE;
         err       <= 1'b0;
`ifdef CMD_FILL_EN
         fill_cnt  <= '0;
         fill_val  <= '0;
`endif
      end else begin
         in_ack  <= accept;
         vram_we <= 1'b0;
         err     <= 1'b0;
         if (tmo) begin
            err   <= 1'b1;
            state <= ST_IDLE;
         end else if (accept) begin
            case (state)
               ST_IDLE: begin
                  case (in_data)
                     OP_SET_ADDR: state <= ST_ADDR_HI;
                     OP_WRITE:    state <= ST_LEN;
                     OP_SET_MODE: state <= ST_MODE_ARG;
`ifdef CMD_FILL_EN
                     OP_FILL:     state <= ST_FILL_CH;
`endif
                     default:     err   <= 1'b1;
                  endcase
               end
               ST_ADDR_HI: begin
                  addr_hi <= in_data[ADDR_W-9:0];
                  state   <= ST_ADDR_LO;
               end
               ST_ADDR_LO: begin
                  if (new_addr > LAST_A) err <= 1'b1;
                  else                   ptr <= new_addr;
                  state <= ST_IDLE;
               end
               ST_LEN: begin
                  remaining <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                  state     <= ST_DATA;
               end
               ST_DATA: begin
                  vram_we   <= 1'b1;
                  vram_addr <= ptr;
                  vram_data <= in_data;
                  ptr       <= ptr_next;
                  remaining <= remaining - 1'b1;
                  if (remaining == 9'd1) state <= ST_IDLE;
               end
               ST_MODE_ARG: begin
                  mode_out <= in_data[2:0];
                  state    <= ST_IDLE;
               end
`ifdef CMD_FILL_EN
               ST_FILL_CH: begin
                  fill_cnt[15:8] <= in_data;
                  state          <= ST_FILL_CL;
               end
               ST_FILL_CL: begin
                  fill_cnt[7:0] <= in_data;
                  state         <= ST_FILL_VAL;
               end
               ST_FILL_VAL: begin
                  fill_val <= in_data;
                  state    <= (fill_cnt == 16'd0) ? ST_IDLE : ST_FILL_RUN;
               end
`endif
               default: state <= ST_IDLE;
            endcase
`ifdef CMD_FILL_EN
         end else if (state == ST_FILL_RUN) begin
            vram_we   <= 1'b1;
            vram_addr <= ptr;
            vram_data <= fill_val;
            ptr       <= ptr_next;
            fill_cnt  <= fill_cnt - 1'b1;
            if (fill_cnt == 16'd1) state <= ST_IDLE;
`endif
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb/tb_uart_cmd_decoder.sv - directed self-checking bench for uart_cmd_decoder (CMD_FILL_EN optional)
module tb_uart_cmd_decoder;

   localparam int ADDR_W = 15;
   localparam int TMO    = 40;

   logic              clk10m = 1'b0;
   logic              rst = 1'b1;
   logic [7:0]        in_data = 8'h00;
   logic              in_valid = 1'b0;
   logic              in_ack;
   logic [ADDR_W-1:0] vram_addr;
   logic [7:0]        vram_data;
   logic              vram_we;
   logic [2:0]        mode_out;
   logic              busy;
   logic              err;

   int total = 0;
   int passed = 0;
   int cyc = 0;
   int err_cnt = 0;
   int we_err_both = 0;
   int ack_during_we = 0;
   int wr_addr[$];
   int wr_data[$];
   int wr_cyc[$];

   uart_cmd_decoder #(
      .ADDR_W(ADDR_W), .VRAM_LAST(22499), .TIMEOUT_CYCLES(TMO), .RESET_MODE(3'd1)
   ) dut (
      .clk10m(clk10m), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ack(in_ack),
      .vram_addr(vram_addr), .vram_data(vram_data), .vram_we(vram_we),
      .mode_out(mode_out), .busy(busy), .err(err)
   );

   always #50 clk10m = ~clk10m;

   always @(negedge clk10m) begin
      cyc <= cyc + 1;
      if (!rst) begin
         if (vram_we) begin
            wr_addr.push_back(int'(vram_addr));
            wr_data.push_back(int'(vram_data));
            wr_cyc.push_back(cyc);
         end
         if (err) err_cnt = err_cnt + 1;
         if (err && vram_we) we_err_both = we_err_both + 1;
         if (in_ack && vram_we) ack_during_we = ack_during_we + 1;
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic chk_wr(input string tag, input int i, input int a, input int d);
      chk({tag, "_addr"}, (i < wr_addr.size()) ? wr_addr[i] : -1, a);
      chk({tag, "_data"}, (i < wr_data.size()) ? wr_data[i] : -1, d);
   endtask

   task automatic send(input logic [7:0] b);
      bit got = 0;
      in_data  = b;
      in_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk10m); #1;
         if (in_ack) begin
            got = 1;
            break;
         end
      end
      in_valid = 1'b0;
      if (!got) chk("ack_timeout", 0, 1);
      @(posedge clk10m); #1;
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      wr_cyc.delete();
   endtask

   initial begin
      repeat (3) @(posedge clk10m);
      #1;
      chk("rst_in_ack", int'(in_ack), 0);
      chk("rst_vram_we", int'(vram_we), 0);
      chk("rst_vram_addr", int'(vram_addr), 0);
      chk("rst_vram_data", int'(vram_data), 0);
      chk("rst_mode", int'(mode_out), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_err", int'(err), 0);
      rst = 1'b0;
      @(posedge clk10m); #1;

      // 1: addressed write of three bytes
      send(8'hA0); send(8'h00); send(8'h10);
      send(8'hA1); send(8'h03); send(8'h11);
      chk("t1_busy_mid", int'(busy), 1);
      send(8'h22); send(8'h33);
      chk("t1_nwr", wr_addr.size(), 3);
      chk_wr("t1_w0", 0, 16'h0010, 8'h11);
      chk_wr("t1_w1", 1, 16'h0011, 8'h22);
      chk_wr("t1_w2", 2, 16'h0012, 8'h33);
      chk("t1_strobe_gap", (wr_cyc.size() == 3) ? int'(wr_cyc[1] - wr_cyc[0] > 1) : 0, 1);
      chk("t1_busy_end", int'(busy), 0);
      chk("t1_err", err_cnt, 0);
      clear_log();

      // 2: write across the last VRAM address wraps to 0
      send(8'hA0); send(8'h57); send(8'hE3);
      send(8'hA1); send(8'h02); send(8'hAA); send(8'hBB);
      chk("t2_nwr", wr_addr.size(), 2);
      chk_wr("t2_w0", 0, 22499, 8'hAA);
      chk_wr("t2_w1", 1, 0, 8'hBB);
      clear_log();

      // 3: out-of-range address, unknown opcode, mode change
      send(8'hA0); send(8'h7F); send(8'hFF);
      chk("t3_err_addr", err_cnt, 1);
      send(8'hA1); send(8'h01); send(8'hCC);
      chk_wr("t3_ptr_kept", 0, 1, 8'hCC);
      send(8'h5A);
      chk("t3_err_op", err_cnt, 2);
      chk("t3_nwr", wr_addr.size(), 1);
`ifndef CMD_FILL_EN
      send(8'hA3);
      chk("t3_err_fill_off", err_cnt, 3);
      err_cnt = 2;
`endif
      send(8'hA2); send(8'h02);
      chk("t3_mode", int'(mode_out), 2);
      clear_log();

      // 4: partial packet abandoned by the inter-byte timeout
      send(8'hA1); send(8'h05); send(8'h01); send(8'h02);
      chk("t4_busy_wait", int'(busy), 1);
      repeat (TMO + 10) @(posedge clk10m);
      #1;
      chk("t4_nwr", wr_addr.size(), 2);
      chk_wr("t4_w0", 0, 2, 8'h01);
      chk_wr("t4_w1", 1, 3, 8'h02);
      chk("t4_err", err_cnt, 3);
      chk("t4_idle", int'(busy), 0);
      send(8'hA2); send(8'h00);
      chk("t4_mode", int'(mode_out), 0);
      clear_log();

      // 5: reset in the middle of a write packet
      send(8'hA1); send(8'h04); send(8'h77);
      rst = 1'b1;
      @(posedge clk10m); #1;
      rst = 1'b0;
      chk("t5_mode", int'(mode_out), 1);
      chk("t5_busy", int'(busy), 0);
      chk("t5_nwr", wr_addr.size(), 1);
      chk_wr("t5_w0", 0, 4, 8'h77);
      send(8'hA1); send(8'h01); send(8'h99);
      chk_wr("t5_ptr_zero", 1, 0, 8'h99);
      clear_log();

`ifdef CMD_FILL_EN
      // 6: fill burst; next byte held off until the burst ends
      send(8'hA0); send(8'h00); send(8'h00);
      send(8'hA3); send(8'h00); send(8'h04);
      in_data  = 8'h20;
      in_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk10m); #1;
         if (in_ack) break;
      end
      in_valid = 1'b0;
      @(posedge clk10m); #1;
      send(8'hA2);
      send(8'h05);
      chk("t6_nwr", wr_addr.size(), 4);
      for (int i = 0; i < 4; i++) chk_wr("t6_w", i, i, 8'h20);
      chk("t6_consec", (wr_cyc.size() == 4) ? wr_cyc[3] - wr_cyc[0] : -1, 3);
      chk("t6_no_ack", ack_during_we, 0);
      chk("t6_mode", int'(mode_out), 5);
      clear_log();
`endif

      chk("we_err_exclusive", we_err_both, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
